vmem_rom_bank_ctrl: RTL and testbench

Parametrised successor to the graphics-cart video microprocessor ROM bank array. It holds NUM_BANKS word-wide ROM banks, each selected by an active-low ROMOUT_b line, with the MA18 overlay forcing the top word-address bit. Reads use a registered request/acknowledge handshake with configurable wait states, optional page-mode bursts with in-bank address wrap, and select-conflict and no-select flags. It sits between the video memory bus (MA_from_VMEM in, MD_to_VMEM out) and the cartridge ROM storage.

---
 rtl/vmem_rom_bank_ctrl.sv | 152 +++++++++++++++
 tb/tb_vmem_rom_bank_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vmem_rom_bank_ctrl.sv
// -----------------------------------------------------------------------------
// vmem_rom_bank_ctrl
//
// Banked cartridge ROM behind the video memory bus. NUM_BANKS word-wide banks
// are selected by active-low ROMOUT_b lines. MA18_b overlays the top
// word-address bit. Reads use a request/ack handshake with a fixed number of
// wait states. An optional burst returns BURST_LEN beats, and the address wraps
// inside the latched bank.
//
// Ports
//   clk           rising-edge clock
//   rst_b         asynchronous active-low reset
//   ROMOUT_b      active-low bank selects, sampled with the request
//   MA18_b        active-low overlay, forces the top word-address bit
//   MA_from_VMEM  byte address (bit 0 ignored)
//   rd_req        read request, accepted only while idle
//   burst         sampled with rd_req, selects a BURST_LEN-beat read
//   MD_to_VMEM    registered read data, held between acks
//   rd_ack        one-cycle pulse per beat
//   busy          high whenever a transaction is in flight
//   sel_err       with ack: more than one select was low
//   no_sel        with ack: no select was low (data is all ones)
// -----------------------------------------------------------------------------
module vmem_rom_bank_ctrl #(
    parameter int NUM_BANKS   = 3,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2,
    parameter int BURST_LEN   = 4,
    parameter     INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [NUM_BANKS-1:0] ROMOUT_b,
    input  logic                 MA18_b,
    input  logic [ADDR_W:0]      MA_from_VMEM,
    input  logic                 rd_req,
    input  logic                 burst,
    output logic [DATA_W-1:0]    MD_to_VMEM,
    output logic                 rd_ack,
    output logic                 busy,
    output logic                 sel_err,
    output logic                 no_sel
);

    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ROM_DEPTH = NUM_BANKS << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t r_state, w_next;

    // Bank b occupies words b*2^ADDR_W upward, so {bank, wa} is the flat index.
    logic [DATA_W-1:0] r_rom [0:ROM_DEPTH-1];

    logic [BANK_W-1:0]        r_bank, w_bank;
    logic [ADDR_W-1:0]        r_wa, w_wa;
    logic [4:0]               r_beats;
    logic [3:0]               r_wcnt;
    logic                     r_sel_err, r_no_sel;
    logic                     w_multi, w_found;
    logic                     w_last;
    logic [BANK_W+ADDR_W-1:0] w_rom_idx;
    logic [DATA_W-1:0]        w_rom_data;

    // Priority decode: the lowest active select wins; any further active
    // select marks a conflict.
    always_comb begin
        w_bank  = '0;
        w_found = 1'b0;
        w_multi = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!ROMOUT_b[b]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end else begin
                    w_bank  = BANK_W'(b);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign w_wa       = {MA_from_VMEM[ADDR_W] | ~MA18_b, MA_from_VMEM[ADDR_W-1:1]};
    assign w_rom_idx  = {r_bank, r_wa};
    assign w_rom_data = r_rom[w_rom_idx];
    assign w_last     = (r_beats == 5'd1);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (rd_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            S_WAIT: if (r_wcnt == 4'd0) w_next = S_DATA;
            S_DATA: if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The wait counter is loaded with WAIT_STATES-1, so WAIT lasts exactly
    // WAIT_STATES cycles. The last beat's ack is registered on the same edge
    // that returns the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            MD_to_VMEM <= '0;
            rd_ack     <= 1'b0;
            sel_err    <= 1'b0;
            no_sel     <= 1'b0;
            r_bank     <= '0;
            r_wa       <= '0;
            r_beats    <= '0;
            r_wcnt     <= '0;
            r_sel_err  <= 1'b0;
            r_no_sel   <= 1'b0;
        end else begin
            rd_ack  <= 1'b0;
            sel_err <= 1'b0;
            no_sel  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        r_bank    <= w_bank;
                        r_wa      <= w_wa;
                        r_beats   <= burst ? 5'(BURST_LEN) : 5'd1;
                        r_wcnt    <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
                        r_sel_err <= w_multi;
                        r_no_sel  <= ~w_found;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
                end
                S_DATA: begin
                    MD_to_VMEM <= r_no_sel ? '1 : w_rom_data;
                    rd_ack     <= 1'b1;
                    sel_err    <= r_sel_err;
                    no_sel     <= r_no_sel;
                    // Natural ADDR_W-bit rollover gives the in-bank wrap.
                    r_wa       <= r_wa + 1'b1;
                    r_beats    <= r_beats - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_rom_bank_ctrl.sv
module tb_vmem_rom_bank_ctrl;
    localparam int WS = 2;
    localparam int BL = 4;
    localparam int AW = 15;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [2:0]  romout = 3'b111;
    logic        ma18_b = 1'b1;
    logic [15:0] ma = 16'h0;
    logic        rd_req = 1'b0;
    logic        rd_req0 = 1'b0;
    logic        burst = 1'b0;

    logic [15:0] md, md0;
    logic        ack, busy, se, ns;
    logic        ack0, busy0, se0, ns0;

    always #5 clk = ~clk;

    vmem_rom_bank_ctrl #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(16),
                         .WAIT_STATES(WS), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_b(rst_b), .ROMOUT_b(romout), .MA18_b(ma18_b),
        .MA_from_VMEM(ma), .rd_req(rd_req), .burst(burst),
        .MD_to_VMEM(md), .rd_ack(ack), .busy(busy), .sel_err(se), .no_sel(ns));

    vmem_rom_bank_ctrl #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(16),
                         .WAIT_STATES(0), .BURST_LEN(BL)) dut0 (
        .clk(clk), .rst_b(rst_b), .ROMOUT_b(romout), .MA18_b(ma18_b),
        .MA_from_VMEM(ma), .rd_req(rd_req0), .burst(burst),
        .MD_to_VMEM(md0), .rd_ack(ack0), .busy(busy0), .sel_err(se0), .no_sel(ns0));

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ROM image: a scrambled function of the flat word index with one marker word.
    function automatic logic [15:0] img(int idx);
        if (idx == 2) return 16'hA55A;
        return 16'((idx * 40503) ^ (idx >> 5) ^ 16'h3C5A);
    endfunction

    function automatic int wa_of(logic [15:0] a, logic m18);
        return ((int'(a) >> 1) & 'h3FFF) | ((a[15] || !m18) ? 'h4000 : 0);
    endfunction

    typedef struct {
        int          cyc;
        logic [15:0] d;
        bit          se;
        bit          ns;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          free_at = 0;
    int          last_n = -100;
    logic [15:0] last_md = 16'h0;

    // Reference model: on each accepted request, enumerate every beat the
    // transaction must produce, with the cycle it must appear in.
    int m_bank, m_nlow, m_wa, m_len;
    always @(posedge clk) begin
        cyc++;
        if (rst_b && rd_req && cyc >= free_at) begin
            m_bank = -1;
            m_nlow = 0;
            for (int b = 0; b < NB; b++)
                if (!romout[b]) begin
                    m_nlow++;
                    if (m_bank < 0) m_bank = b;
                end
            m_wa  = wa_of(ma, ma18_b);
            m_len = burst ? BL : 1;
            for (int j = 0; j < m_len; j++) begin
                exp_t e;
                e.cyc = cyc + WS + 1 + j;
                e.ns  = (m_nlow == 0);
                e.se  = (m_nlow > 1);
                e.d   = e.ns ? 16'hFFFF : img(m_bank * (1 << AW) + ((m_wa + j) % (1 << AW)));
                q.push_back(e);
            end
            last_n  = cyc;
            free_at = cyc + WS + m_len + 1;
        end
    end

    // Monitor: compares ack beats against the queue and checks idle behaviour.
    always @(negedge clk) begin
        if (rst_b) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("ack", 32'(ack), 32'd1);
                chk("md", 32'(md), 32'(e.d));
                chk("sel_err", 32'(se), 32'(e.se));
                chk("no_sel", 32'(ns), 32'(e.ns));
                last_md = e.d;
            end else begin
                if (ack) chk("spurious_ack", 32'(ack), 32'd0);
                if (se || ns) chk("flag_outside_ack", 32'({se, ns}), 32'd0);
                chk("md_hold", 32'(md), 32'(last_md));
            end
            chk("busy", 32'(busy), 32'(cyc >= last_n && cyc < free_at - 1));
        end
    end

    task automatic do_reset();
        rst_b   = 1'b0;
        q.delete();
        free_at = 0;
        last_n  = -100;
        last_md = 16'h0;
    endtask

    // Called just after a rising edge; waits until the model is idle, then
    // presents one request for exactly one edge and scrambles the inputs.
    task automatic issue(input logic [2:0] ro, input logic m18, input logic [15:0] a,
                         input logic b);
        int g = 0;
        while (cyc + 1 < free_at && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        romout = ro; ma18_b = m18; ma = a; burst = b; rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        romout = 3'($urandom); ma = 16'($urandom); ma18_b = 1'($urandom); burst = 1'($urandom);
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() > 0 || busy) && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  ro;
        logic [15:0] exp0;
        for (int i = 0; i < (NB << AW); i++) begin
            dut.r_rom[i]  = img(i);
            dut0.r_rom[i] = img(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_md", 32'(md), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({se, ns}), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        // Directed reads: marker word, overlay on/off, burst wrap, select faults.
        issue(3'b110, 1'b1, 16'h0004, 1'b0);
        issue(3'b101, 1'b0, 16'h0002, 1'b0);
        issue(3'b101, 1'b1, 16'h0002, 1'b0);
        issue(3'b011, 1'b1, 16'hFFFC, 1'b1);
        issue(3'b000, 1'b1, 16'h0010, 1'b0);
        issue(3'b111, 1'b1, 16'h0010, 1'b0);
        drain();

        // Request held high through bursts: only idle-time accepts count.
        romout = 3'b110; ma18_b = 1'b1; burst = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ma = 16'($urandom);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        drain();

        // Reset during WAIT: outputs clear at once, no ack afterwards.
        issue(3'b110, 1'b1, 16'h0020, 1'b0);
        do_reset();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_md", 32'(md), 32'd0);
        chk("abort_flags", 32'({se, ns}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic, mostly single-select.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                ro = 3'b001 << $urandom_range(0, 2);
                ro = ~ro;
            end else begin
                ro = 3'($urandom);
            end
            issue(ro, 1'($urandom), 16'($urandom), 1'($urandom));
        end
        drain();

        // Zero-wait-state instance: ack one cycle after accept, accepts every 2 cycles.
        romout = 3'b101; ma18_b = 1'b1; burst = 1'b0; ma = 16'($urandom);
        rd_req0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            exp0 = img((1 << AW) + wa_of(ma, ma18_b));
            #1;
            ma = 16'($urandom);
            @(negedge clk);
            chk("ws0_no_ack_yet", 32'(ack0), 32'd0);
            chk("ws0_busy", 32'(busy0), 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk("ws0_ack", 32'(ack0), 32'd1);
            chk("ws0_md", 32'(md0), 32'(exp0));
            chk("ws0_busy_lo", 32'(busy0), 32'd0);
        end
        rd_req0 = 1'b0;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
